// File: rtl/gcm_len_ctrl.sv
// GCM length sequencer: counts AAD/CT bytes per message and emits the GHASH length block.
// Optional macro GCM_LEN_LIMIT_EN adds the AAD/CT maximum-length checks.
module gcm_len_ctrl #(
  parameter int unsigned CNT_W         = 61,
  parameter logic [63:0] CT_MAX_BYTES  = 64'h0000000FFFFFFFE0,
  parameter logic [63:0] AAD_MAX_BYTES = 64'h1FFFFFFFFFFFFFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         start_has_aad,
  input  logic         aad_valid,
  output logic         aad_ready,
  input  logic [4:0]   aad_bytes,
  input  logic         aad_last,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [4:0]   ct_bytes,
  input  logic         ct_last,
  output logic         len_valid,
  input  logic         len_ready,
  output logic [127:0] len_block,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE, AAD, CT, EMIT, ERR
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] aad_cnt, ct_cnt;
  logic [CNT_W:0]   aad_sum, ct_sum;
  logic             aad_acc, ct_acc;
  logic             aad_lim, ct_lim;
  logic             aad_bad, ct_bad;
  logic [63:0]      aad_bits, ct_bits_n;

  assign aad_acc = (state == AAD) && aad_valid;
  assign ct_acc  = (state == CT) && ct_valid;

  assign aad_sum = {1'b0, aad_cnt} + (CNT_W+1)'(aad_bytes);
  assign ct_sum  = {1'b0, ct_cnt} + (CNT_W+1)'(ct_bytes);

`ifdef GCM_LEN_LIMIT_EN
  assign aad_lim = 64'(aad_sum) > AAD_MAX_BYTES;
  assign ct_lim  = 64'(ct_sum) > CT_MAX_BYTES;
`else
  assign aad_lim = 1'b0;
  assign ct_lim  = 1'b0;
  wire unused_lim = ^{CT_MAX_BYTES, AAD_MAX_BYTES};
`endif

  assign aad_bad = (aad_bytes > 5'd16)
                || (!aad_last && aad_bytes != 5'd16)
                || aad_sum[CNT_W] || aad_lim;
  assign ct_bad  = (ct_bytes > 5'd16)
                || (!ct_last && ct_bytes != 5'd16)
                || ct_sum[CNT_W] || ct_lim;

  assign aad_bits  = 64'({aad_cnt, 3'b000});
  assign ct_bits_n = 64'({ct_sum[CNT_W-1:0], 3'b000});

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // next-state: start overrides everything, bad beats park in ERR
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = start_has_aad ? AAD : CT;
    end else begin
      case (state)
        AAD: if (aad_acc) begin
          if (aad_bad)       state_n = ERR;
          else if (aad_last) state_n = CT;
        end
        CT: if (ct_acc) begin
          if (ct_bad)       state_n = ERR;
          else if (ct_last) state_n = EMIT;
        end
        EMIT: if (len_ready) state_n = IDLE;
        default: ;
      endcase
    end
  end

  // counters, sticky error and the registered length block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aad_cnt   <= '0;
      ct_cnt    <= '0;
      err       <= 1'b0;
      len_block <= '0;
    end else if (start) begin
      aad_cnt   <= '0;
      ct_cnt    <= '0;
      err       <= 1'b0;
      len_block <= '0;
    end else begin
      if (aad_acc) begin
        if (aad_bad) err <= 1'b1;
        else         aad_cnt <= aad_sum[CNT_W-1:0];
      end
      if (ct_acc) begin
        if (ct_bad) begin
          err <= 1'b1;
        end else begin
          ct_cnt <= ct_sum[CNT_W-1:0];
          if (ct_last) len_block <= {aad_bits, ct_bits_n};
        end
      end
    end
  end

  // handshake outputs decoded from state
  always_comb begin
    aad_ready = (state == AAD);
    ct_ready  = (state == CT);
    len_valid = (state == EMIT);
    done      = (state == EMIT) && len_ready;
    busy      = (state != IDLE);
  end

endmodule

// File: doc/gcm_len_ctrl.md
Name: gcm_len_ctrl

Overview:
- Per-message length sequencer for the GCM GHASH path.
- Accepts AAD and ciphertext beat descriptors (byte counts per 128-bit block) from the stream front-end and accumulates byte totals.
- Enforces beat ordering and framing rules.
- At message end, presents the 128-bit length block (len(AAD)||len(CT) in bits) to GHASH over a valid/ready handshake, then signals completion.

Parameters:
- CNT_W, 61: width of each byte counter; bit count = {cnt, 3'b000} zero-extended to 64. Legal range 8..61.
- CT_MAX_BYTES, 64'h0000000FFFFFFFE0: max CT bytes (2^36-32). Used only with GCM_LEN_LIMIT_EN.
- AAD_MAX_BYTES, 64'h1FFFFFFFFFFFFFFF: max AAD bytes (2^61-1). Used only with GCM_LEN_LIMIT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new message, clears counters.
- start_has_aad  in  1  sampled with start; 1 selects AAD phase first, 0 goes straight to CT phase.
- aad_valid  in  1  AAD beat descriptor valid.
- aad_ready  out  1  AAD beat accepted when aad_valid & aad_ready.
- aad_bytes  in  5  bytes in beat, 0..16.
- aad_last  in  1  final AAD beat.
- ct_valid  in  1  CT beat descriptor valid.
- ct_ready  out  1  CT beat accepted when ct_valid & ct_ready.
- ct_bytes  in  5  bytes in beat, 0..16.
- ct_last  in  1  final CT beat.
- len_valid  out  1  len_block valid to GHASH.
- len_ready  in  1  GHASH accepts len_block.
- len_block  out  128  {aad_bits[63:0], ct_bits[63:0]}.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on len_block transfer.
- err  out  1  sticky framing/overflow error; cleared only by start or reset.

Behaviour:
- States: IDLE, AAD, CT, EMIT, ERR.
- Reset values: state = IDLE; both counters = 0; aad_ready = 0, ct_ready = 0, len_valid = 0, done = 0, err = 0, busy = 0; len_block = 0.
- aad_ready = (state == AAD). ct_ready = (state == CT). Both are combinational from state.
- start, accepted in any state, aborts any message in progress:
  - clears counters and err;
  - next state is AAD if start_has_aad, else CT.
- AAD state:
  - accepted beat adds aad_bytes to aad_cnt, visible the next cycle;
  - accepted beat with aad_last moves to CT next cycle.
- CT state:
  - accepted beat adds ct_bytes to ct_cnt;
  - accepted beat with ct_last moves to EMIT next cycle, with len_valid = 1 that cycle.
- Empty message parts:
  - empty AAD: start_has_aad = 0;
  - empty CT: a single beat with ct_bytes = 0 and ct_last = 1;
  - a zero-byte last beat is also legal in AAD.
- Framing errors; the erroring beat is consumed (ready high), then the state goes to ERR next cycle with err = 1:
  - any beat with bytes > 16;
  - a non-last beat with bytes != 16;
  - counter carry-out beyond CNT_W.
- ERR state:
  - aad_ready = 0, ct_ready = 0, len_valid = 0;
  - exits only via start.
- EMIT state:
  - len_valid = 1, held until len_ready;
  - len_block stays stable while len_valid & !len_ready;
  - on handshake: done = 1 for that cycle only, next state IDLE.
  - If start coincides with the handshake, the transfer completes (done = 1) and the next state is AAD/CT per start_has_aad.
- len_block is registered: it is loaded on entry to EMIT and retained after transfer until the next start.
- Beats presented in IDLE or EMIT are not accepted (ready = 0); they are not an error.

Optional Feature:
- Macro GCM_LEN_LIMIT_EN.
- Defined: in addition to the framing checks, an accepted beat whose new total would exceed AAD_MAX_BYTES (AAD) or CT_MAX_BYTES (CT) raises err and enters ERR. Comparison is on the post-add value. These are the SP 800-38D length limits.
- Undefined: no limit comparators are synthesised; only CNT_W carry-out overflow is checked.

Test Plan:
- AAD beats 16, 4(last); CT beats 16, 16, 16, 12(last); len_ready = 1 -> len_block = 128'h00000000000000A0_00000000000001E0, done pulses 1 cycle, busy falls next cycle.
- start_has_aad = 0; CT beat 0 bytes with last -> len_block = 128'h0, len_valid asserted cycle after beat acceptance.
- Same message as scenario 1 with len_ready held low 5 cycles -> len_valid high and len_block stable all 5 cycles, done only on cycle len_ready = 1.
- AAD non-last beat with 8 bytes -> beat accepted, err = 1 next cycle, aad_ready = 0 and ct_ready = 0 thereafter; start clears err, new message completes normally.
- CNT_W = 8: 16 CT beats of 16 bytes (total 256) -> err on the 16th beat, len_valid never asserted.
- GCM_LEN_LIMIT_EN with CT_MAX_BYTES = 32: CT beats 16, 16, 16(last) -> err on third beat; without the macro, len_block CT field = 64'd384.
